backlight_spi_tx: RTL and testbench



---
 rtl/bdd_pkg.sv | 24 ++
 rtl/bdd_sclk_gen.sv | 50 +++++
 rtl/backlight_spi_tx.sv | 204 ++++++++++++++++++++
 tb/tb_backlight_spi_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bdd_pkg.sv
// Shared constants, FSM state type and grayscale expansion for the backlight SPI transmitter.
package bdd_pkg;

    localparam int unsigned NUM_BLOCKS = 24;
    localparam int unsigned BLOCK_W    = 8;
    localparam int unsigned GS_W       = 12;
    localparam int unsigned TOTAL_BITS = NUM_BLOCKS * GS_W;

    localparam int unsigned ZONE_W   = $clog2(NUM_BLOCKS);
    localparam int unsigned GSIDX_W  = $clog2(GS_W);
    localparam int unsigned BITCNT_W = $clog2(TOTAL_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_e;

    // Widen a zone value to driver grayscale width by replicating its MSBs into the LSBs.
    function automatic logic [GS_W-1:0] gs_expand(input logic [BLOCK_W-1:0] v);
        return {v, v[BLOCK_W-1 -: GS_W-BLOCK_W]};
    endfunction

endpackage

// File: rtl/bdd_sclk_gen.sv
// Serial clock divider: SCLK low then high for CLK_DIV cycles each, with edge-anticipating ticks.
module bdd_sclk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_tick_c_o,
    output logic fall_tick_c_o
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             wrap_c;

    assign wrap_c = (cnt_q == DIV_W'(CLK_DIV - 1));

    // Ticks flag the edge on which SCLK is about to toggle.
    assign rise_tick_c_o = en_i && wrap_c && !sclk_q;
    assign fall_tick_c_o = en_i && wrap_c &&  sclk_q;
    assign sclk_o        = sclk_q;

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (wrap_c) begin
            cnt_d  = '0;
            sclk_d = !sclk_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/backlight_spi_tx.sv
// Ships the 24-zone block vector to a daisy-chained LED-driver string over SCLK/SDO/LAT.
// Optional: define BDD_TX_SKIP_UNCHANGED_EN to suppress frames whose data matches the last sent frame.
module backlight_spi_tx
    import bdd_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned LAT_W   = 4
) (
    input  logic                          iODCK,
    input  logic                          iRST,
    input  logic [NUM_BLOCKS*BLOCK_W-1:0] iBlockData,
    input  logic                          iFrameStart,
    output logic                          oSCLK,
    output logic                          oSDO,
    output logic                          oLAT,
    output logic                          oBusy,
    output logic                          oOverrun
);

    localparam int unsigned LATCNT_W = $clog2(LAT_W + 1);

    state_e                               state_q, state_d;
    logic [NUM_BLOCKS-1:0][BLOCK_W-1:0]   shadow_q, shadow_d;
    logic [BITCNT_W-1:0]                  bitcnt_q, bitcnt_d;
    logic [ZONE_W-1:0]                    zone_q, zone_d;
    logic [GSIDX_W-1:0]                   gsbit_q, gsbit_d;
    logic [LATCNT_W-1:0]                  latcnt_q, latcnt_d;
    logic                                 final_q, final_d;
    logic                                 busy_q, busy_d;
    logic                                 lat_q, lat_d;
    logic                                 sdo_q, sdo_d;
    logic                                 ovr_q, ovr_d;

    logic                                 accept_c;
    logic                                 skip_c;
    logic                                 rise_tick_c;
    logic                                 fall_tick_c;
    logic [GS_W-1:0]                      first_gs_c;
    logic [ZONE_W-1:0]                    nxt_zone_c;
    logic [GSIDX_W-1:0]                   nxt_gsbit_c;
    logic [GS_W-1:0]                      nxt_gs_c;

    bdd_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk           (iODCK),
        .rst_n         (iRST),
        .en_i          (state_q == SHIFT),
        .sclk_o        (oSCLK),
        .rise_tick_c_o (rise_tick_c),
        .fall_tick_c_o (fall_tick_c)
    );

    assign accept_c   = iFrameStart && (state_q == IDLE);
    assign first_gs_c = gs_expand(iBlockData[(NUM_BLOCKS-1)*BLOCK_W +: BLOCK_W]);

    // Walk zones high to low, each zone MSB first.
    always_comb begin
        nxt_zone_c  = zone_q;
        nxt_gsbit_c = gsbit_q - GSIDX_W'(1);
        if (gsbit_q == '0) begin
            nxt_gsbit_c = GSIDX_W'(GS_W - 1);
            if (zone_q != '0) begin
                nxt_zone_c = zone_q - ZONE_W'(1);
            end
        end
    end

    assign nxt_gs_c = gs_expand(shadow_q[nxt_zone_c]);

`ifdef BDD_TX_SKIP_UNCHANGED_EN
    logic [NUM_BLOCKS*BLOCK_W-1:0] prev_q, prev_d;
    logic                          sent_q, sent_d;

    assign skip_c = sent_q && (iBlockData == prev_q);

    always_comb begin
        prev_d = prev_q;
        sent_d = sent_q;
        if (accept_c && !skip_c) begin
            prev_d = iBlockData;
            sent_d = 1'b1;
        end
    end

    always_ff @(posedge iODCK or negedge iRST) begin
        if (!iRST) begin
            prev_q <= '0;
            sent_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            sent_q <= sent_d;
        end
    end
`else
    assign skip_c = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        bitcnt_d = bitcnt_q;
        zone_d   = zone_q;
        gsbit_d  = gsbit_q;
        latcnt_d = latcnt_q;
        final_d  = final_q;
        busy_d   = busy_q;
        lat_d    = lat_q;
        sdo_d    = sdo_q;
        ovr_d    = ovr_q;

        // Overrun is sticky; an accepted strobe clears it.
        if (iFrameStart && busy_q) begin
            ovr_d = 1'b1;
        end
        if (accept_c) begin
            ovr_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    shadow_d = iBlockData;
                    if (!skip_c) begin
                        state_d  = SHIFT;
                        busy_d   = 1'b1;
                        bitcnt_d = BITCNT_W'(TOTAL_BITS - 1);
                        zone_d   = ZONE_W'(NUM_BLOCKS - 1);
                        gsbit_d  = GSIDX_W'(GS_W - 1);
                        final_d  = 1'b0;
                        sdo_d    = first_gs_c[GS_W-1];
                    end
                end
            end
            SHIFT: begin
                if (rise_tick_c && (bitcnt_q == '0)) begin
                    final_d = 1'b1;
                end
                if (fall_tick_c) begin
                    if (final_q) begin
                        state_d  = LATCH;
                        lat_d    = 1'b1;
                        sdo_d    = 1'b0;
                        latcnt_d = '0;
                    end else begin
                        bitcnt_d = bitcnt_q - BITCNT_W'(1);
                        zone_d   = nxt_zone_c;
                        gsbit_d  = nxt_gsbit_c;
                        sdo_d    = nxt_gs_c[nxt_gsbit_c];
                    end
                end
            end
            LATCH: begin
                if (latcnt_q == LATCNT_W'(LAT_W - 1)) begin
                    state_d = IDLE;
                    lat_d   = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    latcnt_d = latcnt_q + LATCNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                lat_d   = 1'b0;
                busy_d  = 1'b0;
                sdo_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iODCK or negedge iRST) begin
        if (!iRST) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            bitcnt_q <= '0;
            zone_q   <= '0;
            gsbit_q  <= '0;
            latcnt_q <= '0;
            final_q  <= 1'b0;
            busy_q   <= 1'b0;
            lat_q    <= 1'b0;
            sdo_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            bitcnt_q <= bitcnt_d;
            zone_q   <= zone_d;
            gsbit_q  <= gsbit_d;
            latcnt_q <= latcnt_d;
            final_q  <= final_d;
            busy_q   <= busy_d;
            lat_q    <= lat_d;
            sdo_q    <= sdo_d;
            ovr_q    <= ovr_d;
        end
    end

    assign oSDO     = sdo_q;
    assign oLAT     = lat_q;
    assign oBusy    = busy_q;
    assign oOverrun = ovr_q;

endmodule

// File: tb/tb_backlight_spi_tx.sv
// Directed self-checking bench for backlight_spi_tx (default build; skip-unchanged steps under its macro).
module tb_backlight_spi_tx;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [191:0] blk;
    logic         fs;
    logic         sclk, sdo, lat, busy, ovr;

    int tests = 0;
    int fails = 0;

    logic rec [4096];
    int   rise_total = 0;

    always #5 clk = ~clk;

    backlight_spi_tx dut (
        .iODCK       (clk),
        .iRST        (rst_n),
        .iBlockData  (blk),
        .iFrameStart (fs),
        .oSCLK       (sclk),
        .oSDO        (sdo),
        .oLAT        (lat),
        .oBusy       (busy),
        .oOverrun    (ovr)
    );

    // Record SDO at every SCLK rising edge.
    always @(posedge sclk) begin
        if (rise_total < 4096) rec[rise_total] = sdo;
        rise_total++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [191:0] d, input int i);
        int         z;
        int         b;
        logic [7:0]  v;
        logic [11:0] g;
        z = 23 - i / 12;
        b = 11 - i % 12;
        v = d[z*8 +: 8];
        g = {v, v[7:4]};
        return g[b];
    endfunction

    task automatic strobe();
        @(negedge clk);
        fs = 1'b1;
        @(posedge clk);
        #1;
        fs = 1'b0;
    endtask

    // Follows a frame from just after its strobe edge until oBusy drops (bounded).
    task automatic run_frame(input bit toggle, output int lat_start, output int lat_len,
                             output int busy_end);
        lat_start = -1;
        lat_len   = 0;
        busy_end  = -1;
        for (int k = 1; k < 5000; k++) begin
            @(posedge clk);
            #1;
            if (lat && lat_start < 0) lat_start = k;
            if (lat) lat_len++;
            if (!busy) begin
                busy_end = k;
                break;
            end
            if (toggle) blk = ~blk;
        end
    endtask

    task automatic chk_stream(input string tag, input logic [191:0] d, input int base);
        int errs;
        errs = 0;
        for (int i = 0; i < 288; i++) begin
            if (rec[base + i] !== exp_bit(d, i)) errs++;
        end
        chk(tag, errs, 0);
    endtask

    initial begin
        logic [191:0] d_a, d_b, d_c, d2;
        logic [11:0]  w;
        int base, ls, ll, be, ones;

        for (int z = 0; z < 24; z++) begin
            d_a[z*8 +: 8] = 8'(z * 11 + 3);
            d_b[z*8 +: 8] = 8'(z * 37 + 100);
            d_c[z*8 +: 8] = 8'(8'hC3 ^ z);
        end
        d2 = '0;
        d2[23*8 +: 8] = 8'h80;
        d2[7:0] = 8'h01;

        rst_n = 1'b0;
        fs    = 1'b0;
        blk   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sclk", sclk, 0);
        chk("rst_sdo", sdo, 0);
        chk("rst_lat", lat, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", ovr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // All zones 0xFF
        blk  = {24{8'hFF}};
        base = rise_total;
        strobe();
        chk("t1_busy_t1", busy, 1);
        chk("t1_sdo_t1", sdo, 1);
        run_frame(1'b0, ls, ll, be);
        chk("t1_lat_start", ls, 2304);
        chk("t1_lat_len", ll, 4);
        chk("t1_busy_end", be, 2308);
        chk("t1_rises", rise_total - base, 288);
        ones = 0;
        for (int i = 0; i < 288; i++) if (rec[base + i] === 1'b1) ones++;
        chk("t1_ones", ones, 288);

        // Zone 23 = 0x80, zone 0 = 0x01, strobe on the first idle cycle
        blk  = d2;
        base = rise_total;
        strobe();
        chk("t2_busy_t1", busy, 1);
        chk("t2_sdo_t1", sdo, 1);
        run_frame(1'b0, ls, ll, be);
        chk("t2_rises", rise_total - base, 288);
        w = '0;
        for (int i = 0; i < 12; i++) w = {w[10:0], rec[base + i]};
        chk("t2_first12", w, 12'h808);
        w = '0;
        for (int i = 276; i < 288; i++) w = {w[10:0], rec[base + i]};
        chk("t2_last12", w, 12'h010);
        chk_stream("t2_stream", d2, base);

        // Strobe while busy: ignored, overrun sticky
        blk  = d_a;
        base = rise_total;
        strobe();
        repeat (100) @(posedge clk);
        @(negedge clk);
        blk = '0;
        fs  = 1'b1;
        @(posedge clk);
        #1;
        fs = 1'b0;
        chk("t3_ovr_set", ovr, 1);
        chk("t3_busy_kept", busy, 1);
        run_frame(1'b0, ls, ll, be);
        chk("t3_lat_len", ll, 4);
        chk("t3_rises", rise_total - base, 288);
        chk_stream("t3_stream", d_a, base);
        chk("t3_ovr_held", ovr, 1);

        // Accepted strobe clears overrun; reset mid-transfer
        blk = d_b;
        strobe();
        chk("t4_ovr_clr", ovr, 0);
        chk("t4_busy", busy, 1);
        repeat (1004) @(posedge clk);
        #1;
        chk("t4_sclk_hi", sclk, 1);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_sclk", sclk, 0);
        chk("t4_rst_sdo", sdo, 0);
        chk("t4_rst_lat", lat, 0);
        chk("t4_rst_busy", busy, 0);

        // Strobe at reset release, input toggled during SHIFT
        @(negedge clk);
        blk   = d_c;
        base  = rise_total;
        rst_n = 1'b1;
        fs    = 1'b1;
        @(posedge clk);
        #1;
        fs = 1'b0;
        chk("t5_busy_t1", busy, 1);
        run_frame(1'b1, ls, ll, be);
        chk("t5_lat_start", ls, 2304);
        chk("t5_busy_end", be, 2308);
        chk("t5_rises", rise_total - base, 288);
        chk_stream("t5_stream", d_c, base);

`ifdef BDD_TX_SKIP_UNCHANGED_EN
        // Identical data twice: second strobe is silent
        blk  = d_a;
        base = rise_total;
        strobe();
        run_frame(1'b0, ls, ll, be);
        chk("s1_rises", rise_total - base, 288);
        chk("s1_lat_len", ll, 4);
        base = rise_total;
        strobe();
        ones = 0;
        for (int k = 0; k < 50; k++) begin
            if (busy || lat || sclk) ones++;
            @(posedge clk);
            #1;
        end
        chk("s2_quiet", ones, 0);
        chk("s2_rises", rise_total - base, 0);
        blk[7:0] = blk[7:0] ^ 8'h01;
        base = rise_total;
        strobe();
        run_frame(1'b0, ls, ll, be);
        chk("s3_rises", rise_total - base, 288);
        chk("s3_busy_end", be, 2308);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
